// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multiply/divide sequencer with an iterative restoring divider.
// Optional flush port and abort path enabled by defining MULDIV_FLUSH_EN.
module muldiv_seq #(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MULDIV_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_y
);

    localparam int ITER = XLEN / DIV_UNROLL;
    localparam int CW   = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] qr;
    logic [XLEN-1:0] dv;
    logic [CW-1:0]   cnt;
    logic            neg_q;
    logic            rem_q;

    logic            kill;
    logic            accept;

`ifdef MULDIV_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign accept     = req_valid & req_ready & ~kill;

    // Request decode
    logic            is_div;
    logic            sgn;
    logic            is_rem;
    logic            sa;
    logic            sb;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic            neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] spec_y;

    assign is_div  = req_op[2];
    assign sgn     = ~req_op[0];
    assign is_rem  = req_op[1];
    assign sa      = (req_op[1:0] == 2'b01) | (req_op[1:0] == 2'b10);
    assign sb      = (req_op[1:0] == 2'b01);
    assign b_zero  = (req_b == '0);
    assign ovf     = sgn & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (&req_b);
    assign special = b_zero | ovf;
    assign neg     = sgn & (is_rem ? req_a[XLEN-1]
                                   : req_a[XLEN-1] ^ req_b[XLEN-1]);
    assign a_mag   = (sgn & req_a[XLEN-1]) ? (~req_a + 1'b1) : req_a;
    assign b_mag   = (sgn & req_b[XLEN-1]) ? (~req_b + 1'b1) : req_b;

    // Special-case divide results resolved without iterating
    always_comb begin
        spec_y = '0;
        if (b_zero)
            spec_y = is_rem ? req_a : '1;
        else if (ovf)
            spec_y = is_rem ? '0 : req_a;
    end

    // Full 64-bit product; sign extension picks the signed/unsigned flavour
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_y;

    assign a_ext = {{XLEN{sa & req_a[XLEN-1]}}, req_a};
    assign b_ext = {{XLEN{sb & req_b[XLEN-1]}}, req_b};
    assign prod  = a_ext * b_ext;
    assign mul_y = (req_op[1:0] == 2'b00) ? prod[XLEN-1:0]
                                          : prod[2*XLEN-1:XLEN];

    // Restoring shift-subtract, DIV_UNROLL quotient bits per cycle, MSB first
    logic [XLEN-1:0] acc_n;
    logic [XLEN-1:0] qr_n;
    logic [XLEN:0]   t;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] fin_raw;
    logic [XLEN-1:0] fin;

    always_comb begin
        acc_n = acc;
        qr_n  = qr;
        t     = '0;
        diff  = '0;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            t    = {acc_n, qr_n[XLEN-1]};
            diff = t - {1'b0, dv};
            if (!diff[XLEN]) begin
                acc_n = diff[XLEN-1:0];
                qr_n  = {qr_n[XLEN-2:0], 1'b1};
            end else begin
                acc_n = t[XLEN-1:0];
                qr_n  = {qr_n[XLEN-2:0], 1'b0};
            end
        end
    end

    assign fin_raw = rem_q ? acc_n : qr_n;
    assign fin     = neg_q ? (~fin_raw + 1'b1) : fin_raw;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_d = (is_div && !special) ? S_DIV : S_DONE;
            end
            S_DIV: begin
                if (cnt == CW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill)
            state_d = S_IDLE;
    end

    // Operand latching, divider iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            qr     <= '0;
            dv     <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            rem_q  <= 1'b0;
            resp_y <= '0;
        end else if (!kill) begin
            if (accept) begin
                if (!is_div) begin
                    resp_y <= mul_y;
                end else if (special) begin
                    resp_y <= spec_y;
                end else begin
                    acc   <= '0;
                    qr    <= a_mag;
                    dv    <= b_mag;
                    cnt   <= CW'(ITER);
                    neg_q <= neg;
                    rem_q <= is_rem;
                end
            end else if (state == S_DIV) begin
                acc <= acc_n;
                qr  <= qr_n;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1))
                    resp_y <= fin;
            end
        end
    end

endmodule
